// File: rtl/ahb_lite_txn_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_txn_capture_pkg
// Description : Shared AHB-Lite types for the transaction capture tap:
//               transfer/size encodings, capture FSM states, record struct.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_lite_txn_capture_pkg;

  localparam int ADDRWIDTH = 32;
  localparam int DATAWIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  // HSIZE is carried verbatim, so a plain 3-bit type is all that is needed.
  typedef logic [2:0] hsize_t;

  localparam hsize_t HSIZE_BYTE = 3'd0;
  localparam hsize_t HSIZE_HALF = 3'd1;
  localparam hsize_t HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] data;
    logic                 write;
    hsize_t               size;
    logic                 err;
  } ahb_rec_t;

  // NONSEQ and SEQ are the only transfer types that open a data phase.
  function automatic logic htrans_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage : ahb_lite_txn_capture_pkg
`default_nettype wire

// File: rtl/ahb_lite_txn_capture_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ahb_rec_fifo
// Description : Single-clock show-ahead FIFO of ahb_rec_t records. A push
//               into a full FIFO is accepted when a pop happens in the same
//               cycle. While empty the head output keeps the last record
//               that was popped.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_rec_fifo
  import ahb_lite_txn_capture_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ahb_rec_t               push_rec,
  input  logic                   pop,
  output ahb_rec_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  ahb_rec_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  ahb_rec_t         hold_q, hold_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == C_DEPTH);
  assign level   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? hold_q : mem_q[rd_ptr_q];

  // Next pointer/occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset flushes the FIFO by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_rec;
  end

endmodule : ahb_rec_fifo
`default_nettype wire

// File: rtl/ahb_lite_txn_capture.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_txn_capture
// Description : Passive AHB-Lite tap. Pairs each accepted address phase with
//               its data phase (wait states and two-cycle ERROR included) and
//               pushes one record per completed transfer into a FIFO. Records
//               that find the FIFO full are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_txn_capture
  import ahb_lite_txn_capture_pkg::*;
#(
  parameter int ADDR_W     = ADDRWIDTH,
  parameter int DATA_W     = DATAWIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HSEL,
  input  logic [ADDR_W-1:0]           HADDR,
  input  logic                        HWRITE,
  input  logic [2:0]                  HSIZE,
  input  logic [1:0]                  HTRANS,
  input  logic                        HREADY,
  input  logic                        HRESP,
  input  logic [DATA_W-1:0]           HWDATA,
  input  logic [DATA_W-1:0]           HRDATA,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output ahb_rec_t                    rec,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [CNT_W-1:0]            ovf_cnt
);

  cap_state_t           state_q, state_d;
  logic [ADDRWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                 pend_write_q, pend_write_d;
  hsize_t               pend_size_q, pend_size_d;
  logic [CNT_W-1:0]     ovf_q, ovf_d;

  logic     accept;
  logic     push;
  ahb_rec_t push_rec;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;

  assign accept    = HREADY & HSEL & htrans_active(htrans_t'(HTRANS));
  assign rec_valid = ~fifo_empty;
  assign pop       = rec_valid & rec_ready;
  assign ovf_cnt   = ovf_q;

  // Capture FSM: completes the pending data phase and may accept the next
  // address phase on the same edge (pipelined back-to-back transfers).
  always_comb begin
    state_d        = state_q;
    pend_addr_d    = pend_addr_q;
    pend_write_d   = pend_write_q;
    pend_size_d    = pend_size_q;
    push           = 1'b0;
    push_rec       = '0;
    push_rec.addr  = pend_addr_q;
    push_rec.write = pend_write_q;
    push_rec.size  = pend_size_q;

    case (state_q)
      ST_DATA: begin
        if (HREADY) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          if (HRESP) begin
            // ERROR seen only with HREADY high: still recorded as an error.
            push_rec.err  = 1'b1;
            push_rec.data = '0;
          end else begin
            push_rec.err  = 1'b0;
            push_rec.data = pend_write_q ? HWDATA : HRDATA;
          end
        end else if (HRESP) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        // Second ERROR cycle always closes the transfer, whatever the bus shows.
        push          = 1'b1;
        push_rec.err  = 1'b1;
        push_rec.data = '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d      = ST_DATA;
      pend_addr_d  = HADDR;
      pend_write_d = HWRITE;
      pend_size_d  = HSIZE;
    end
  end

  // Dropped-record counter: a push is lost only if full with no same-cycle pop.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  // State, pending address-phase register and overflow counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
      pend_size_q  <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
      pend_size_q  <= pend_size_d;
      ovf_q        <= ovf_d;
    end
  end

  ahb_rec_fifo #(
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

endmodule : ahb_lite_txn_capture
`default_nettype wire

// File: tb/tb_ahb_lite_txn_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_txn_capture
// Description : Directed self-checking bench for the AHB-Lite capture tap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_txn_capture;
  import ahb_lite_txn_capture_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        rec_valid;
  logic        rec_ready;
  ahb_rec_t    rec;
  logic [3:0]  level;
  logic [15:0] ovf_cnt;

  int vectors = 0;
  int miscompares = 0;

  ahb_lite_txn_capture #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec       (rec),
    .level     (level),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [2:0] sz, input logic e);
    chk({tag, ".valid"}, 128'(rec_valid), 128'(1'b1));
    chk({tag, ".addr"},  128'(rec.addr),  128'(a));
    chk({tag, ".data"},  128'(rec.data),  128'(d));
    chk({tag, ".write"}, 128'(rec.write), 128'(w));
    chk({tag, ".size"},  128'(rec.size),  128'(sz));
    chk({tag, ".err"},   128'(rec.err),   128'(e));
  endtask

  // Drive one bus cycle, take the edge, settle 1 time unit after it.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic [2:0] sz, input logic rdy,
                     input logic rsp, input logic [31:0] wd, input logic [31:0] rd);
    HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = wr; HSIZE = sz;
    HREADY = rdy; HRESP = rsp; HWDATA = wd; HRDATA = rd;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic pop_one();
    rec_ready = 1'b1;
    idle_cyc();
    rec_ready = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; rec_ready = 1'b0;
    idle_cyc();
    idle_cyc();
    HRESET = 1'b0;
    idle_cyc();
    chk("rst.valid", 128'(rec_valid), 128'(0));
    chk("rst.level", 128'(level), 128'(0));
    chk("rst.ovf",   128'(ovf_cnt), 128'(0));
    chk("rst.rec",   128'(rec), 128'(0));

    // Zero-wait write 0x10 = 0xDEADBEEF
    cyc(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wr.addr_phase_valid", 128'(rec_valid), 128'(0));
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    chk_rec("wr", 32'h10, 32'hDEADBEEF, 1'b1, 3'd2, 1'b0);
    chk("wr.level", 128'(level), 128'(1));
    pop_one();
    chk("wr.pop_valid", 128'(rec_valid), 128'(0));
    chk("wr.pop_level", 128'(level), 128'(0));
    chk("wr.hold_addr", 128'(rec.addr), 128'(32'h10));
    // rec_ready while empty is ignored
    pop_one();
    chk("empty_pop.level", 128'(level), 128'(0));

    // Read 0x20 with 3 wait states
    cyc(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'hFFFF0000, 32'hBAD0BAD0);
    chk("rd.wait_level", 128'(level), 128'(0));
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'hFFFF0000, 32'h12345678);
    chk_rec("rd", 32'h20, 32'h12345678, 1'b0, 3'd2, 1'b0);
    idle_cyc();
    chk("rd.one_rec", 128'(level), 128'(1));
    pop_one();

    // Pipelined NONSEQ 0x0, SEQ 0x4, SEQ 0x8
    cyc(1'b1, 2'd2, 32'h0, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0,        32'h0);
    cyc(1'b1, 2'd3, 32'h4, 1'b1, 3'd2, 1'b1, 1'b0, 32'hA0000000, 32'h0);
    cyc(1'b1, 2'd3, 32'h8, 1'b1, 3'd2, 1'b1, 1'b0, 32'hA0000001, 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'hA0000002, 32'h0);
    chk("pipe.level", 128'(level), 128'(3));
    chk_rec("pipe0", 32'h0, 32'hA0000000, 1'b1, 3'd2, 1'b0);
    pop_one();
    chk_rec("pipe1", 32'h4, 32'hA0000001, 1'b1, 3'd2, 1'b0);
    pop_one();
    chk_rec("pipe2", 32'h8, 32'hA0000002, 1'b1, 3'd2, 1'b0);
    pop_one();

    // Two-cycle ERROR on write to 0x3FC
    cyc(1'b1, 2'd2, 32'h3FC, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h55555555, 32'h0);
    chk("err.cycle1_level", 128'(level), 128'(0));
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1, 32'h55555555, 32'h0);
    chk_rec("err", 32'h3FC, 32'h0, 1'b1, 3'd2, 1'b1);
    pop_one();

    // Ten pipelined writes with no consumer: 8 kept, 2 dropped
    for (int k = 0; k <= 10; k++)
      cyc(1'b1, (k < 10) ? 2'd2 : 2'd0, 32'(k * 4), 1'b1, 3'd2, 1'b1, 1'b0,
          (k == 0) ? 32'h0 : (32'hC0000000 + 32'(k - 1)), 32'h0);
    chk("ovf.level", 128'(level), 128'(8));
    chk("ovf.cnt",   128'(ovf_cnt), 128'(2));
    chk_rec("ovf.head", 32'h0, 32'hC0000000, 1'b1, 3'd2, 1'b0);
    // 11th transfer pushes while full with a same-cycle pop
    cyc(1'b1, 2'd2, 32'h100, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    rec_ready = 1'b1;
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'hC00000AA, 32'h0);
    rec_ready = 1'b0;
    chk("fullpop.level", 128'(level), 128'(8));
    chk("fullpop.cnt",   128'(ovf_cnt), 128'(2));
    chk("fullpop.head",  128'(rec.addr), 128'(32'h4));
    rec_ready = 1'b1;
    for (int i = 0; i < 7; i++) idle_cyc();
    rec_ready = 1'b0;
    chk("drain.level", 128'(level), 128'(1));
    chk_rec("drain.last", 32'h100, 32'hC00000AA, 1'b1, 3'd2, 1'b0);
    pop_one();
    chk("drain.empty", 128'(rec_valid), 128'(0));

    // Reset during a wait-stated read
    cyc(1'b1, 2'd2, 32'h40, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    HRESET = 1'b1;
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    HRESET = 1'b0;
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h77777777);
    chk("rstmid.level", 128'(level), 128'(0));
    chk("rstmid.valid", 128'(rec_valid), 128'(0));
    chk("rstmid.ovf",   128'(ovf_cnt), 128'(0));
    chk("rstmid.rec",   128'(rec), 128'(0));
    cyc(1'b1, 2'd2, 32'h50, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0BADF00D, 32'h0);
    chk_rec("post_rst", 32'h50, 32'h0BADF00D, 1'b1, 3'd0, 1'b0);
    chk("post_rst.level", 128'(level), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ahb_lite_txn_capture
`default_nettype wire
